// File: rtl/fp_mult_result_fifo_if.sv
// Handshake bundle between the FP multiplier, the result FIFO and its consumer.
// master = producer/consumer side, slave = FIFO side.
interface fp_mult_result_fifo_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic        in_exception;
   logic        in_overflow;
   logic        in_underflow;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [2:0]  out_flags;

   modport master (
      output in_valid, in_result, in_exception, in_overflow, in_underflow, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_result, in_exception, in_overflow, in_underflow, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/fp_mult_result_fifo.sv
// First-word-fall-through FIFO for FP multiplier results plus per-flag saturating
// event counters and sticky flags; one-cycle push-to-head latency, in_ready from state only.
module fp_mult_result_fifo #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   fp_mult_result_fifo_if.slave      bus,
   output logic [$clog2(DEPTH):0]    level,
   input  logic                      clr_stats,
   output logic [CNT_W-1:0]          exc_count,
   output logic [CNT_W-1:0]          ovf_count,
   output logic [CNT_W-1:0]          unf_count,
   output logic [2:0]                sticky_flags
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0] result;
      logic [2:0]  flags;
   } entry_t;

   entry_t            mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic              push;
   logic              pop;
   entry_t            wr_ent;
   entry_t            head;
   logic [CNT_W-1:0]  cnt [3];

   assign wr_ent.result = bus.in_result;
   assign wr_ent.flags  = {bus.in_exception, bus.in_overflow, bus.in_underflow};

   // Ready is masked by reset so nothing is offered to the producer during a reset cycle.
   assign bus.in_ready  = rst_n & (level != LEVEL_FULL);
   assign bus.out_valid = (level != '0);
   assign push          = bus.in_valid & bus.in_ready;
   assign pop           = bus.out_valid & bus.out_ready;

   assign head           = mem[rd_ptr];
   assign bus.out_result = head.result;
   assign bus.out_flags  = head.flags;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_ent;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            level <= level + 1'b1;
         end else if (pop && !push) begin
            level <= level - 1'b1;
         end
      end
   end

   // Clear wins over a same-cycle push: that word's flags are neither counted nor made sticky.
   always_ff @(posedge clk) begin
      if (!rst_n || clr_stats) begin
         for (int i = 0; i < 3; i++) begin
            cnt[i] <= '0;
         end
         sticky_flags <= '0;
      end else if (push) begin
         for (int i = 0; i < 3; i++) begin
            if (wr_ent.flags[i] && (cnt[i] != '1)) begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
         sticky_flags <= sticky_flags | wr_ent.flags;
      end
   end

   assign exc_count = cnt[2];
   assign ovf_count = cnt[1];
   assign unf_count = cnt[0];
endmodule

// File: tb/tb_fp_mult_result_fifo.sv
// Drives two FIFO instances (16-bit and 2-bit counters) with identical stimulus and
// checks both against a queue-based reference model every cycle.
module tb_fp_mult_result_fifo;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_result;
   logic [2:0]  in_fl;
   logic        out_ready;
   logic        clr_stats;

   logic [2:0]  level_a, level_b;
   logic [15:0] exc_a, ovf_a, unf_a;
   logic [1:0]  exc_b, ovf_b, unf_b;
   logic [2:0]  sticky_a, sticky_b;

   fp_mult_result_fifo_if ia ();
   fp_mult_result_fifo_if ib ();

   assign ia.in_valid     = in_valid;
   assign ia.in_result    = in_result;
   assign ia.in_exception = in_fl[2];
   assign ia.in_overflow  = in_fl[1];
   assign ia.in_underflow = in_fl[0];
   assign ia.out_ready    = out_ready;
   assign ib.in_valid     = in_valid;
   assign ib.in_result    = in_result;
   assign ib.in_exception = in_fl[2];
   assign ib.in_overflow  = in_fl[1];
   assign ib.in_underflow = in_fl[0];
   assign ib.out_ready    = out_ready;

   fp_mult_result_fifo #(.DEPTH(DEPTH), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ia), .level(level_a), .clr_stats(clr_stats),
      .exc_count(exc_a), .ovf_count(ovf_a), .unf_count(unf_a), .sticky_flags(sticky_a)
   );

   fp_mult_result_fifo #(.DEPTH(DEPTH), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ib), .level(level_b), .clr_stats(clr_stats),
      .exc_count(exc_b), .ovf_count(ovf_b), .unf_count(unf_b), .sticky_flags(sticky_b)
   );

   always #5 clk = ~clk;

   // Reference model: queue of {result, flags}, raw (unsaturated) event totals, sticky OR.
   logic [34:0] q[$];
   int          raw_cnt [3];
   logic [2:0]  m_sticky;

   int passes = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] sat(input int raw, input int w);
      int m;
      m = (1 << w) - 1;
      return (raw > m) ? 64'(m) : 64'(raw);
   endfunction

   task automatic check_outputs();
      logic        exp_rdy;
      logic [34:0] hd;
      exp_rdy = rst_n && (q.size() < DEPTH);
      chk("in_ready_a", 64'(ia.in_ready), 64'(exp_rdy));
      chk("in_ready_b", 64'(ib.in_ready), 64'(exp_rdy));
      chk("out_valid_a", 64'(ia.out_valid), 64'(q.size() > 0));
      chk("level_a", 64'(level_a), 64'(q.size()));
      chk("level_b", 64'(level_b), 64'(q.size()));
      if (q.size() > 0) begin
         hd = q[0];
         chk("head_result_a", 64'(ia.out_result), 64'(hd[34:3]));
         chk("head_flags_a", 64'(ia.out_flags), 64'(hd[2:0]));
         chk("head_result_b", 64'(ib.out_result), 64'(hd[34:3]));
      end
      chk("exc_a", 64'(exc_a), sat(raw_cnt[2], 16));
      chk("ovf_a", 64'(ovf_a), sat(raw_cnt[1], 16));
      chk("unf_a", 64'(unf_a), sat(raw_cnt[0], 16));
      chk("exc_b", 64'(exc_b), sat(raw_cnt[2], 2));
      chk("ovf_b", 64'(ovf_b), sat(raw_cnt[1], 2));
      chk("unf_b", 64'(unf_b), sat(raw_cnt[0], 2));
      chk("sticky_a", 64'(sticky_a), 64'(m_sticky));
      chk("sticky_b", 64'(sticky_b), 64'(m_sticky));
   endtask

   task automatic model_edge();
      bit do_push, do_pop;
      if (!rst_n) begin
         q.delete();
         raw_cnt  = '{0, 0, 0};
         m_sticky = '0;
      end else begin
         do_push = in_valid && (q.size() < DEPTH);
         do_pop  = out_ready && (q.size() > 0);
         if (do_pop) q.delete(0);
         if (do_push) q.push_back({in_result, in_fl});
         if (clr_stats) begin
            raw_cnt  = '{0, 0, 0};
            m_sticky = '0;
         end else if (do_push) begin
            for (int i = 0; i < 3; i++) if (in_fl[i]) raw_cnt[i]++;
            m_sticky = m_sticky | in_fl;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_in(input logic v, input logic [31:0] r, input logic [2:0] f,
                         input logic ordy);
      in_valid  = v;
      in_result = r;
      in_fl     = f;
      out_ready = ordy;
   endtask

   initial begin
      rst_n = 1'b0;
      clr_stats = 1'b0;
      set_in(1'b0, 32'h0, 3'b000, 1'b0);
      q.delete();
      raw_cnt  = '{0, 0, 0};
      m_sticky = '0;
      @(posedge clk);
      #1;
      step();
      chk("rst_out_result", 64'(ia.out_result), 64'h0);
      chk("rst_out_flags", 64'(ia.out_flags), 64'h0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 64'(ia.in_ready), 64'h1);

      // Single push then pop.
      set_in(1'b1, 32'h4040_0000, 3'b000, 1'b0);
      step();
      set_in(1'b0, 32'h0, 3'b000, 1'b0);
      chk("t1_level", 64'(level_a), 64'd1);
      chk("t1_head", 64'(ia.out_result), 64'h4040_0000);
      out_ready = 1'b1;
      step();
      chk("t1_empty", 64'(ia.out_valid), 64'h0);

      // Fill to full, then pop with producer waiting: no push that cycle.
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 32'h1000_0000 + 32'(i), 3'b000, 1'b0);
         step();
      end
      chk("t2_full_level", 64'(level_a), 64'd4);
      chk("t2_full_rdy", 64'(ia.in_ready), 64'h0);
      set_in(1'b1, 32'h1000_0004, 3'b000, 1'b1);
      step();
      chk("t2_no_push_on_full", 64'(level_a), 64'd3);
      out_ready = 1'b0;
      step();
      chk("t2_late_push", 64'(level_a), 64'd4);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // Streaming push&pop across pointer wrap.
      set_in(1'b1, 32'h2000_0000, 3'b000, 1'b0);
      step();
      for (int i = 1; i <= 10; i++) begin
         set_in(1'b1, 32'h2000_0000 + 32'(i), 3'(i), 1'b1);
         step();
         chk("t3_level", 64'(level_a), 64'd1);
      end
      set_in(1'b0, 32'h0, 3'b000, 1'b1);
      step();

      // One event per flag.
      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
      set_in(1'b1, 32'h7F80_0000, 3'b010, 1'b1);
      step();
      set_in(1'b1, 32'h0000_0000, 3'b001, 1'b1);
      step();
      set_in(1'b1, 32'h0000_0000, 3'b100, 1'b1);
      step();
      in_valid = 1'b0;
      chk("t4_ovf", 64'(ovf_a), 64'd1);
      chk("t4_unf", 64'(unf_a), 64'd1);
      chk("t4_exc", 64'(exc_a), 64'd1);
      chk("t4_sticky", 64'(sticky_a), 64'h7);
      step();

      // Saturation on the 2-bit counters, then clear beats a flagged push.
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 32'h3000_0000 + 32'(i), 3'b010, 1'b1);
         step();
      end
      chk("t5_ovf_sat", 64'(ovf_b), 64'd3);
      chk("t5_ovf_wide", 64'(ovf_a), 64'd6);
      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
      in_valid  = 1'b0;
      chk("t5_clr_ovf", 64'(ovf_b), 64'd0);
      chk("t5_clr_sticky", 64'(sticky_b), 64'h0);
      for (int i = 0; i < 2; i++) step();

      // Mid-stream reset discards contents.
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 32'h4000_0000 + 32'(i), 3'b111, 1'b0);
         step();
      end
      rst_n = 1'b0;
      set_in(1'b1, 32'hDEAD_BEEF, 3'b111, 1'b1);
      #1;
      chk("t6_rdy_in_rst", 64'(ia.in_ready), 64'h0);
      step();
      chk("t6_level", 64'(level_a), 64'd0);
      chk("t6_valid", 64'(ia.out_valid), 64'h0);
      chk("t6_exc", 64'(exc_a), 64'd0);
      rst_n = 1'b1;
      set_in(1'b0, 32'h0, 3'b000, 1'b0);
      #1;
      chk("t6_rdy_after", 64'(ia.in_ready), 64'h1);

      // Randomized traffic with occasional clear and reset.
      for (int i = 0; i < 400; i++) begin
         set_in(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom),
                1'($urandom_range(0, 2) != 0));
         clr_stats = ($urandom_range(0, 24) == 0);
         rst_n     = ($urandom_range(0, 79) != 0);
         step();
      end
      rst_n = 1'b1;
      clr_stats = 1'b0;
      step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end
endmodule
